// File: rtl/display_7seg_multiplexado_pkg.sv
// ---------------------------------------------------------------------------
// display_7seg_multiplexado_pkg
// Shared definitions for the multiplexed 7-segment display driver.
// Segment codes are 7 bits ordered {a,b,c,d,e,f,g} and active-low. A 0 bit
// lights the segment. The decimal point is appended as the LSB of the
// 8-bit pin word.
// No ports (package).
// ---------------------------------------------------------------------------
package display_7seg_multiplexado_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t APAGADO = 7'b111_1111;

    localparam seg7_t CERO    = 7'b000_0001;
    localparam seg7_t UNO     = 7'b100_1111;
    localparam seg7_t DOS     = 7'b001_0010;
    localparam seg7_t TRES    = 7'b000_0110;
    localparam seg7_t CUATRO  = 7'b100_1100;
    localparam seg7_t CINCO   = 7'b010_0100;
    localparam seg7_t SEIS    = 7'b010_0000;
    localparam seg7_t SIETE   = 7'b000_1111;
    localparam seg7_t OCHO    = 7'b000_0000;
    localparam seg7_t NUEVE   = 7'b000_0100;

    localparam seg7_t HEX_A   = 7'b000_1000;
    localparam seg7_t HEX_B   = 7'b110_0000;
    localparam seg7_t HEX_C   = 7'b011_0001;
    localparam seg7_t HEX_D   = 7'b100_0010;
    localparam seg7_t HEX_E   = 7'b011_0000;
    localparam seg7_t HEX_F   = 7'b011_1000;

    // Bit position of the decimal point inside the 8-bit segment word
    localparam int POS_DP = 0;

endpackage

// File: rtl/display_7seg_multiplexado_decodificador.sv
// ---------------------------------------------------------------------------
// decodificador_7seg
// Combinational nibble to 7-segment decoder (active-low, {a..g}).
// Ports:
//   valor      in  4  nibble to show
//   segmentos  out 7  active-low segment pattern {a,b,c,d,e,f,g}
// Parameter MODO_HEX selects whether 10..15 render as A,b,C,d,E,F
// or stay dark.
// ---------------------------------------------------------------------------
module decodificador_7seg
    import display_7seg_multiplexado_pkg::*;
#(
    parameter bit MODO_HEX = 1'b0
) (
    input  logic [3:0] valor,
    output logic [6:0] segmentos
);

    // Plain lookup. Values above nine fall back to dark unless hex mode
    // is enabled, so a decimal-only build never shows stray letters.
    always_comb begin
        segmentos = APAGADO;
        case (valor)
            4'd0:  segmentos = CERO;
            4'd1:  segmentos = UNO;
            4'd2:  segmentos = DOS;
            4'd3:  segmentos = TRES;
            4'd4:  segmentos = CUATRO;
            4'd5:  segmentos = CINCO;
            4'd6:  segmentos = SEIS;
            4'd7:  segmentos = SIETE;
            4'd8:  segmentos = OCHO;
            4'd9:  segmentos = NUEVE;
            4'd10: segmentos = MODO_HEX ? HEX_A : APAGADO;
            4'd11: segmentos = MODO_HEX ? HEX_B : APAGADO;
            4'd12: segmentos = MODO_HEX ? HEX_C : APAGADO;
            4'd13: segmentos = MODO_HEX ? HEX_D : APAGADO;
            4'd14: segmentos = MODO_HEX ? HEX_E : APAGADO;
            4'd15: segmentos = MODO_HEX ? HEX_F : APAGADO;
            default: segmentos = APAGADO;
        endcase
    end

endmodule

// File: rtl/display_7seg_multiplexado.sv
// ---------------------------------------------------------------------------
// display_7seg_multiplexado
// Time-multiplexed driver for N_DIGITOS common-anode 7-segment digits.
// Ports:
//   clk             in  1            system clock
//   reset           in  1            synchronous, active-high reset
//   valores         in  4*N_DIGITOS  packed digits, [3:0] = digit 0
//   puntos          in  N_DIGITOS    decimal point per digit, 1 = lit
//   blanqueo_ceros  in  1            1 = suppress leading zeros
//   habilitar       in  1            0 = display dark (scan keeps running)
//   anodos          out N_DIGITOS    one-hot digit enable
//   cod7SEG         out 8            {a,b,c,d,e,f,g,dp}, active-low
// ---------------------------------------------------------------------------
module display_7seg_multiplexado
    import display_7seg_multiplexado_pkg::*;
#(
    parameter int N_DIGITOS         = 4,
    parameter int DIV_REFRESCO      = 50000,
    parameter bit MODO_HEX          = 1'b0,
    parameter bit ANODO_ACTIVO_BAJO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4*N_DIGITOS-1:0]   valores,
    input  logic [N_DIGITOS-1:0]     puntos,
    input  logic                     blanqueo_ceros,
    input  logic                     habilitar,
    output logic [N_DIGITOS-1:0]     anodos,
    output logic [7:0]               cod7SEG
);

    localparam int PRE_W = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
    localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV_REFRESCO - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITOS - 1);
    localparam logic [N_DIGITOS-1:0] ANODOS_INACTIVOS = {N_DIGITOS{ANODO_ACTIVO_BAJO}};

    logic [PRE_W-1:0]         prescaler;
    logic [IDX_W-1:0]         indice;
    logic                     tick;
    logic                     inicio_trama;

    logic [4*N_DIGITOS-1:0]   snap_valores;
    logic [N_DIGITOS-1:0]     snap_puntos;
    logic                     snap_blanqueo;

    logic [3:0]               valor_actual;
    logic                     punto_actual;
    logic                     blanco_actual;
    logic [N_DIGITOS-1:0]     ceros_desde;
    logic [N_DIGITOS-1:0]     anodo_sel;
    logic [6:0]               seg_decod;

    assign tick         = (prescaler == PRE_MAX);
    assign inicio_trama = (prescaler == '0) && (indice == '0);

    // Refresh prescaler and digit index. The index only moves on the last
    // prescaler count, so each digit stays lit for DIV_REFRESCO cycles.
    // With a single digit IDX_MAX is zero and the index never leaves 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            indice    <= '0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                indice    <= (indice == IDX_MAX) ? '0 : indice + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Frame snapshot. Capturing only at the start of digit 0 keeps a whole
    // frame coherent even if the datapath updates its result mid-scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_valores  <= '0;
            snap_puntos   <= '0;
            snap_blanqueo <= 1'b0;
        end else if (inicio_trama) begin
            snap_valores  <= valores;
            snap_puntos   <= puntos;
            snap_blanqueo <= blanqueo_ceros;
        end
    end

    // ceros_desde[k] is set when digit k and every digit above it are zero.
    // It is built from the top digit down so each entry reuses the one above.
    always_comb begin
        logic acumulado;
        acumulado   = 1'b1;
        ceros_desde = '0;
        for (int k = N_DIGITOS - 1; k >= 0; k--) begin
            acumulado      = acumulado && (snap_valores[4*k +: 4] == 4'd0);
            ceros_desde[k] = acumulado;
        end
    end

    // Select the digit addressed by the scan index. A loop compare is used
    // instead of a variable part-select so non-power-of-two digit counts
    // never index past the packed word.
    always_comb begin
        valor_actual  = 4'd0;
        punto_actual  = 1'b0;
        blanco_actual = 1'b0;
        anodo_sel     = '0;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (indice == IDX_W'(k)) begin
                valor_actual  = snap_valores[4*k +: 4];
                punto_actual  = snap_puntos[k];
                blanco_actual = (k > 0) && snap_blanqueo && ceros_desde[k];
                anodo_sel[k]  = 1'b1;
            end
        end
    end

    decodificador_7seg #(
        .MODO_HEX (MODO_HEX)
    ) u_decodificador (
        .valor     (valor_actual),
        .segmentos (seg_decod)
    );

    // Registered pin drivers. habilitar acts directly here rather than via
    // the snapshot, so darkening the display takes effect on the next edge.
    // A blanked digit keeps its decimal point.
    always_ff @(posedge clk) begin
        if (reset) begin
            anodos  <= ANODOS_INACTIVOS;
            cod7SEG <= {APAGADO, 1'b1};
        end else if (!habilitar) begin
            anodos  <= ANODOS_INACTIVOS;
            cod7SEG <= {APAGADO, 1'b1};
        end else begin
            anodos  <= ANODO_ACTIVO_BAJO ? ~anodo_sel : anodo_sel;
            cod7SEG <= {(blanco_actual ? APAGADO : seg_decod), ~punto_actual};
        end
    end

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
// ---------------------------------------------------------------------------
// tb_display_7seg_multiplexado
// Self-checking bench for display_7seg_multiplexado. Two instances share the
// same stimulus: dut_a (decimal, active-low anodes) and dut_b (hex mode,
// active-high anodes). A frame-position reference model predicts both
// instances every cycle. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_display_7seg_multiplexado;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    localparam logic [7:0] C0 = 8'b000_0001_1;
    localparam logic [7:0] C1 = 8'b100_1111_1;
    localparam logic [7:0] C2 = 8'b001_0010_1;
    localparam logic [7:0] C3 = 8'b000_0110_1;
    localparam logic [7:0] C4 = 8'b100_1100_1;
    localparam logic [7:0] C5 = 8'b010_0100_1;
    localparam logic [7:0] OFF = 8'hFF;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     valores = 16'h0000;
    logic [3:0]      puntos = 4'b0000;
    logic            blanqueo_ceros = 1'b0;
    logic            habilitar = 1'b1;
    logic [3:0]      anodos_a, anodos_b;
    logic [7:0]      cod_a, cod_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display_7seg_multiplexado #(
        .N_DIGITOS(N), .DIV_REFRESCO(DIV), .MODO_HEX(1'b0), .ANODO_ACTIVO_BAJO(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .valores(valores), .puntos(puntos),
        .blanqueo_ceros(blanqueo_ceros), .habilitar(habilitar),
        .anodos(anodos_a), .cod7SEG(cod_a)
    );

    display_7seg_multiplexado #(
        .N_DIGITOS(N), .DIV_REFRESCO(DIV), .MODO_HEX(1'b1), .ANODO_ACTIVO_BAJO(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .valores(valores), .puntos(puntos),
        .blanqueo_ceros(blanqueo_ceros), .habilitar(habilitar),
        .anodos(anodos_b), .cod7SEG(cod_b)
    );

    // Reference glyphs straight from the segment tables (abc_defg, active-low)
    function automatic logic [6:0] seg_ref(input logic [3:0] v, input bit hex);
        case (v)
            4'd0: return 7'b000_0001;
            4'd1: return 7'b100_1111;
            4'd2: return 7'b001_0010;
            4'd3: return 7'b000_0110;
            4'd4: return 7'b100_1100;
            4'd5: return 7'b010_0100;
            4'd6: return 7'b010_0000;
            4'd7: return 7'b000_1111;
            4'd8: return 7'b000_0000;
            4'd9: return 7'b000_0100;
            4'd10: return hex ? 7'b000_1000 : 7'h7F;
            4'd11: return hex ? 7'b110_0000 : 7'h7F;
            4'd12: return hex ? 7'b011_0001 : 7'h7F;
            4'd13: return hex ? 7'b100_0010 : 7'h7F;
            4'd14: return hex ? 7'b011_0000 : 7'h7F;
            default: return hex ? 7'b011_1000 : 7'h7F;
        endcase
    endfunction

    // Digit idx is blank when blanking is on, idx>0 and the value shifted
    // down to that digit is zero (i.e. it and everything above are zero).
    function automatic logic [7:0] cod_esperado(input int idx, input logic [15:0] vals,
                                                 input logic [3:0] pts, input logic blk,
                                                 input bit hex);
        logic [15:0] resto;
        logic        blanco;
        resto  = vals >> (4 * idx);
        blanco = (idx > 0) && blk && (resto == 16'h0000);
        return {(blanco ? 7'h7F : seg_ref(resto[3:0], hex)), ~pts[idx]};
    endfunction

    // Reference model. pos is the position within a frame (0..FRAME-1)
    // counted from reset. The lit digit is pos/DIV, and the snapshot is
    // refreshed whenever pos is 0. Outputs follow the pre-edge position.
    int          pos = 0;
    logic [15:0] s_val = 16'h0;
    logic [3:0]  s_pts = 4'h0;
    logic        s_blk = 1'b0;
    bit          modelo_ok = 1'b0;
    logic [3:0]  exp_an_a, exp_an_b;
    logic [7:0]  exp_cod_a, exp_cod_b;

    always @(posedge clk) begin
        if (reset) begin
            exp_an_a  <= 4'b1111;
            exp_an_b  <= 4'b0000;
            exp_cod_a <= OFF;
            exp_cod_b <= OFF;
            pos       <= 0;
            s_val     <= 16'h0;
            s_pts     <= 4'h0;
            s_blk     <= 1'b0;
            modelo_ok <= 1'b1;
        end else if (modelo_ok) begin
            if (habilitar) begin
                exp_an_a  <= ~(4'b0001 << (pos / DIV));
                exp_an_b  <= 4'b0001 << (pos / DIV);
                exp_cod_a <= cod_esperado(pos / DIV, s_val, s_pts, s_blk, 1'b0);
                exp_cod_b <= cod_esperado(pos / DIV, s_val, s_pts, s_blk, 1'b1);
            end else begin
                exp_an_a  <= 4'b1111;
                exp_an_b  <= 4'b0000;
                exp_cod_a <= OFF;
                exp_cod_b <= OFF;
            end
            if (pos == 0) begin
                s_val <= valores;
                s_pts <= puntos;
                s_blk <= blanqueo_ceros;
            end
            pos <= (pos + 1) % FRAME;
        end
    end

    task automatic checkOutput(input string nombre, input logic [7:0] actual,
                               input logic [7:0] esperado);
        checks++;
        if (actual !== esperado) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", nombre, actual, esperado, $time);
        end
    endtask

    // Compare process: every negedge once the model has seen a reset
    always @(negedge clk) begin
        if (modelo_ok) begin
            checkOutput("model anodos_a", {4'b0, anodos_a}, {4'b0, exp_an_a});
            checkOutput("model cod_a", cod_a, exp_cod_a);
            checkOutput("model anodos_b", {4'b0, anodos_b}, {4'b0, exp_an_b});
            checkOutput("model cod_b", cod_b, exp_cod_b);
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] p,
                                 input logic b, input logic h);
        valores        = v;
        puntos         = p;
        blanqueo_ceros = b;
        habilitar      = h;
    endtask

    task automatic restart();
        reset = 1'b1;
        tick_n(1);
        reset = 1'b0;
    endtask

    // Walks one frame after a restart: digit d is shown from edge 2+4d on.
    // ca/cb pack the expected codes {d3,d2,d1,d0}.
    task automatic checkFrame(input string nombre, input logic [31:0] ca, input logic [31:0] cb);
        for (int d = 0; d < N; d++) begin
            tick_n((d == 0) ? 2 : DIV);
            checkOutput({nombre, " anodos_a"}, {4'b0, anodos_a}, {4'b0, ~(4'b0001 << d)});
            checkOutput({nombre, " cod_a"}, cod_a, ca[8*d +: 8]);
            checkOutput({nombre, " anodos_b"}, {4'b0, anodos_b}, {4'b0, 4'b0001 << d});
            checkOutput({nombre, " cod_b"}, cod_b, cb[8*d +: 8]);
        end
    endtask

    initial begin
        logic [15:0] rv;
        $display("[TB] start");

        // Reset held three cycles with a live value on the inputs
        applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            checkOutput("reset anodos_a", {4'b0, anodos_a}, 8'h0F);
            checkOutput("reset cod_a", cod_a, OFF);
            checkOutput("reset anodos_b", {4'b0, anodos_b}, 8'h00);
        end
        reset = 1'b0;

        // Scan order 4,3,2,1 then back to digit 0
        checkFrame("scan", {C1, C2, C3, C4}, {C1, C2, C3, C4});
        tick_n(DIV);
        checkOutput("scan wrap anodos_a", {4'b0, anodos_a}, 8'h0E);
        checkOutput("scan wrap cod_a", cod_a, C4);

        // Leading-zero blanking with a dp on a blanked digit
        applyStimulus(16'h0050, 4'b0100, 1'b1, 1'b1);
        restart();
        checkFrame("blank", {OFF, 8'hFE, C5, C0}, {OFF, 8'hFE, C5, C0});

        // Hex digits: dark in decimal build, letters in hex build
        applyStimulus(16'h00AF, 4'b0000, 1'b0, 1'b1);
        restart();
        checkFrame("hex", {C0, C0, OFF, OFF}, {C0, C0, 8'b000_1000_1, 8'b011_1000_1});

        // Mid-frame input change is held off until the next frame
        applyStimulus(16'h1111, 4'b0000, 1'b0, 1'b1);
        restart();
        tick_n(9);
        applyStimulus(16'h2222, 4'b0000, 1'b0, 1'b1);
        tick_n(1);
        checkOutput("snap d2 anodos_a", {4'b0, anodos_a}, 8'h0B);
        checkOutput("snap d2 cod_a", cod_a, C1);
        tick_n(DIV);
        checkOutput("snap d3 cod_a", cod_a, C1);
        tick_n(DIV);
        checkOutput("snap next d0 anodos_a", {4'b0, anodos_a}, 8'h0E);
        checkOutput("snap next d0 cod_a", cod_a, C2);
        habilitar = 1'b0;
        tick_n(1);
        checkOutput("disable anodos_a", {4'b0, anodos_a}, 8'h0F);
        checkOutput("disable cod_a", cod_a, OFF);
        checkOutput("disable anodos_b", {4'b0, anodos_b}, 8'h00);
        habilitar = 1'b1;

        // Reset pulse in the middle of digit 2
        restart();
        tick_n(9);
        reset = 1'b1;
        tick_n(1);
        checkOutput("midreset anodos_b", {4'b0, anodos_b}, 8'h00);
        checkOutput("midreset cod_b", cod_b, OFF);
        reset = 1'b0;
        tick_n(2);
        checkOutput("restart anodos_b", {4'b0, anodos_b}, 8'h01);
        checkOutput("restart anodos_a", {4'b0, anodos_a}, 8'h0E);

        // Randomised run: values with random leading zeros, random dp, blanking,
        // enable toggles, changes at arbitrary phases and occasional resets
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                rv = 16'($urandom_range(0, 65535));
                rv = rv >> (4 * $urandom_range(0, 4));
                applyStimulus(rv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 7) != 0));
            end
            reset = ($urandom_range(0, 149) == 0);
            tick_n(1);
        end
        reset = 1'b0;
        tick_n(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_7seg_multiplexado.md
Name: display_7seg_multiplexado

Overview:
- Time-multiplexed driver for N_DIGITOS common-anode 7-segment digits: converts a packed BCD/hex word to segment codes and scans one digit per refresh tick.
- Generalises the single-digit BCD-to-7SEG conversion with:
  - a digit count parameter;
  - a refresh prescaler;
  - hex mode;
  - per-digit decimal point;
  - leading-zero blanking;
  - a frame-coherent input snapshot.
- Sits between the datapath result registers and the board display pins.

Parameters:
- N_DIGITOS, 4, number of digits scanned (1..8).
- DIV_REFRESCO, 50000, clk cycles each digit stays lit (>=2).
- MODO_HEX, 0, 0 = values 10..15 displayed blank; 1 = displayed as A,b,C,d,E,F.
- ANODO_ACTIVO_BAJO, 1, 1 = anode enables active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- valores  in  4*N_DIGITOS  packed digits; [3:0] = digit 0 (least significant).
- puntos  in  N_DIGITOS  decimal point request per digit; 1 = lit.
- blanqueo_ceros  in  1  1 = suppress leading zeros.
- habilitar  in  1  0 = display dark; scanning continues.
- anodos  out  N_DIGITOS  one-hot digit enable, polarity per ANODO_ACTIVO_BAJO.
- cod7SEG  out  8  segments {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp, always active-low.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset (clk edge with reset=1):
  - prescaler=0, indice=0, snapshot=0;
  - anodos = all inactive;
  - cod7SEG = 8'hFF (APAGADO).
- Prescaler: counts 0..DIV_REFRESCO-1 and wraps. tick = (prescaler == DIV_REFRESCO-1).
- Digit index: indice advances on tick, 0..N_DIGITOS-1, wrapping N_DIGITOS-1 -> 0.
- Snapshot: valores, puntos and blanqueo_ceros are captured into snapshot registers on every edge where prescaler==0 and indice==0 (frame start).
  - This includes the first edge after reset deasserts.
  - Input changes mid-frame are never displayed until the next frame start.
- Outputs: registered, updated every edge from the current indice and the snapshot.
  - They lag indice by one cycle.
  - The first valid pattern appears after the second edge with reset=0.
- Decoding (active-low abc_defg, dp appended as bit0):
  - 0..9 use the team's standard codes.
  - 10..15: 8'hFF if MODO_HEX=0; if MODO_HEX=1: A=000_1000, b=110_0000, C=011_0001, d=100_0010, E=011_0000, F=011_1000.
- Decimal point: cod7SEG[0] = ~snapshot_puntos[indice].
- Leading-zero blanking: digit k>0 is blanked (segments a..g = 1) when all of the following hold:
  - blanqueo_ceros snapshot = 1;
  - its value is 0;
  - all digits above k are 0.
  - Digit 0 is never blanked. The dp of a blanked digit still follows puntos.
- Enable: habilitar=0 forces anodos inactive and cod7SEG=8'hFF on the next edge. habilitar is not snapshotted.
- Anodes: anodos has exactly one active bit (bit = indice) when habilitar=1.
- Reset mid-frame: takes effect on that edge; scanning restarts at digit 0 with a fresh snapshot after release.
- N_DIGITOS=1: indice is constant 0; snapshot is taken whenever prescaler==0.

Decomposition:
- Package/header definiciones.vh holds:
  - segment code constants APAGADO, CERO..NUEVE, HEX_A..HEX_F (7-bit abc_defg);
  - the DP bit position.
- One sub-module is natural: decodificador_7seg (combinational, 4-bit in, MODO_HEX parameter, 7-bit active-low out).
- The rest of the logic (prescaler, scan, snapshot, blanking, output register) stays in the top module.

Test Plan (N_DIGITOS=4, DIV_REFRESCO=4, ANODO_ACTIVO_BAJO=1 unless noted):
1. Reset: hold reset 3 cycles with valores=16'h1234 -> anodos=4'b1111, cod7SEG=8'hFF throughout. Release -> after 2 edges anodos=4'b1110, cod7SEG=8'b100_11001 ("4", dp off).
2. Scan: valores=16'h1234, habilitar=1, puntos=0 -> every 4 cycles the anodes rotate 1110, 1101, 1011, 0111, 1110 with codes 4, 3, 2, 1 = 100_11001, 000_01101, 001_00101, 100_11111.
3. Blanking: valores=16'h0050, blanqueo_ceros=1, puntos=4'b0100 -> digit0=8'b000_00011, digit1=8'b010_01001, digit2=8'b111_11110 (blank, dp lit), digit3=8'hFF.
4. Hex mode: MODO_HEX=1, valores=16'h00AF -> digit0=8'b011_10001 (F), digit1=8'b000_10001 (A). Same stimulus with MODO_HEX=0 -> both 8'hFF.
5. Snapshot/enable: change valores 16'h1111 -> 16'h2222 while indice=2 -> digits 2 and 3 still show "1"; "2" appears only from the next digit-0 slot. habilitar=0 -> anodos=4'b1111, cod7SEG=8'hFF next edge.
6. Mid-frame reset with ANODO_ACTIVO_BAJO=0: pulse reset at indice=2 -> anodos=4'b0000 on that edge; restart at digit 0 (anodos=4'b0001) 2 edges after release.
